comb_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively exercises the team's two-function 4-input combinational block, which produces f1 from a,b,c,d and f2 from w,x,y,z.
- On start, drives all 16 input vectors to both functions, waits a settle time, and samples each output.
- Builds two 16-bit truth tables and compares them against expected tables latched at start.
- Sits between a test/config master and the combinational datapath; used for built-in self-check.

---
 rtl/comb_sweep_pkg.sv | 15 +
 rtl/comb_sweep_ctrl_if.sv | 24 ++
 rtl/comb_sweep_func.sv | 16 +
 rtl/comb_sweep_ctrl.sv | 105 ++++++++++
 tb/tb_comb_sweep_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/comb_sweep_pkg.sv
// Shared types and constants for the truth-table sweep sequencer and its datapath.
package comb_sweep_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VEC = 16;

    // Truth tables of the two functions; bit i is the output for vector index i.
    localparam logic [15:0] F1_GOLDEN = 16'h35A5;
    localparam logic [15:0] F2_GOLDEN = 16'hEEE2;
endpackage

// File: rtl/comb_sweep_ctrl_if.sv
// Configuration/result bus between a test master and the sweep sequencer.
// start/abort are level-sampled pulses; done is a one-cycle pulse; results hold until the next start.
interface comb_sweep_ctrl_if;
    logic        start;
    logic        abort;
    logic [15:0] exp_f1;
    logic [15:0] exp_f2;
    logic        busy;
    logic        done;
    logic [15:0] tt_f1;
    logic [15:0] tt_f2;
    logic [5:0]  mismatch_cnt;
    logic        pass;

    modport master (
        output start, abort, exp_f1, exp_f2,
        input  busy, done, tt_f1, tt_f2, mismatch_cnt, pass
    );

    modport slave (
        input  start, abort, exp_f1, exp_f2,
        output busy, done, tt_f1, tt_f2, mismatch_cnt, pass
    );
endinterface

// File: rtl/comb_sweep_func.sv
// Two independent 4-input functions: f1 over {a,b,c,d}, f2 over {w,x,y,z}, MSB first.
module comb_sweep_func (
    input  logic [3:0] abcd,
    input  logic [3:0] wxyz,
    output logic       f1,
    output logic       f2
);
    logic a, b, c, d, w, x, y, z;

    assign {a, b, c, d} = abcd;
    assign {w, x, y, z} = wxyz;

    // Minimal sums of products for minterms {0,2,5,7,8,10,12,13} and {1,5,6,7,9,10,11,13,14,15}.
    assign f1 = (~b & ~d) | (~a & b & d) | (a & b & ~c);
    assign f2 = (~y & z) | (x & y) | (w & ~x & y);
endmodule

// File: rtl/comb_sweep_ctrl.sv
// Walks all 16 input vectors through the combinational block, builds both truth tables
// and counts mismatches against expected tables latched at start.
module comb_sweep_ctrl
    import comb_sweep_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    comb_sweep_ctrl_if.slave  cfg,
    output logic [3:0]        vec_abcd,
    output logic [3:0]        vec_wxyz,
    input  logic              f1_in,
    input  logic              f2_in,
    output state_t            state
);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [3:0]       LAST_IDX    = 4'(NUM_VEC - 1);

    state_t           next_state;
    logic [3:0]       idx;
    logic [CNT_W-1:0] settle_cnt;
    logic [15:0]      exp_f1_lat;
    logic [15:0]      exp_f2_lat;
    logic             start_ok;

    assign start_ok = cfg.start && !cfg.abort;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok) next_state = DRIVE;
            DRIVE:   if (cfg.abort) next_state = IDLE;
                     else if (settle_cnt == SETTLE_LAST) next_state = SAMPLE;
            SAMPLE:  if (cfg.abort) next_state = IDLE;
                     else if (idx == LAST_IDX) next_state = DONE;
                     else next_state = DRIVE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cfg.busy = (state == DRIVE) || (state == SAMPLE);
        cfg.done = (state == DONE);
        vec_abcd = cfg.busy ? idx : 4'd0;
        vec_wxyz = cfg.busy ? idx : 4'd0;
    end

    // An abort drops the in-flight sample; partial tables and count are left visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx              <= 4'd0;
            settle_cnt       <= '0;
            exp_f1_lat       <= 16'd0;
            exp_f2_lat       <= 16'd0;
            cfg.tt_f1        <= 16'd0;
            cfg.tt_f2        <= 16'd0;
            cfg.mismatch_cnt <= 6'd0;
            cfg.pass         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        exp_f1_lat       <= cfg.exp_f1;
                        exp_f2_lat       <= cfg.exp_f2;
                        cfg.tt_f1        <= 16'd0;
                        cfg.tt_f2        <= 16'd0;
                        cfg.mismatch_cnt <= 6'd0;
                        cfg.pass         <= 1'b0;
                        idx              <= 4'd0;
                        settle_cnt       <= '0;
                    end
                end
                DRIVE: begin
                    if (cfg.abort) cfg.pass <= 1'b0;
                    else           settle_cnt <= settle_cnt + CNT_W'(1);
                end
                SAMPLE: begin
                    if (cfg.abort) begin
                        cfg.pass <= 1'b0;
                    end else begin
                        cfg.tt_f1[idx]   <= f1_in;
                        cfg.tt_f2[idx]   <= f2_in;
                        cfg.mismatch_cnt <= cfg.mismatch_cnt
                                          + {5'd0, f1_in ^ exp_f1_lat[idx]}
                                          + {5'd0, f2_in ^ exp_f2_lat[idx]};
                        if (idx != LAST_IDX) begin
                            idx        <= idx + 4'd1;
                            settle_cnt <= '0;
                        end
                    end
                end
                DONE: cfg.pass <= (cfg.mismatch_cnt == 6'd0);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Directed bench: two sequencers (settle 1 and settle 3) each driving a copy of the real datapath.
module tb_comb_sweep_ctrl;
    import comb_sweep_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    comb_sweep_ctrl_if cfg_a ();
    comb_sweep_ctrl_if cfg_b ();

    logic [3:0] vec_abcd_a, vec_wxyz_a, vec_abcd_b, vec_wxyz_b;
    logic       f1_a, f2_a, f1_raw_b, f2_b, f1_d1_b, f1_d2_b;
    state_t     state_a, state_b;

    comb_sweep_func u_func_a (.abcd(vec_abcd_a), .wxyz(vec_wxyz_a), .f1(f1_a), .f2(f2_a));
    comb_sweep_func u_func_b (.abcd(vec_abcd_b), .wxyz(vec_wxyz_b), .f1(f1_raw_b), .f2(f2_b));

    // f1 reaches the slow sequencer two cycles late, inside its settle window.
    always @(posedge clk) begin
        f1_d1_b <= f1_raw_b;
        f1_d2_b <= f1_d1_b;
    end

    comb_sweep_ctrl #(.SETTLE(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .cfg(cfg_a),
        .vec_abcd(vec_abcd_a), .vec_wxyz(vec_wxyz_a),
        .f1_in(f1_a), .f2_in(f2_a), .state(state_a)
    );

    comb_sweep_ctrl #(.SETTLE(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .cfg(cfg_b),
        .vec_abcd(vec_abcd_b), .vec_wxyz(vec_wxyz_b),
        .f1_in(f1_d2_b), .f2_in(f2_b), .state(state_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [15:0] e1, input logic [15:0] e2);
        cfg_a.exp_f1 = e1;
        cfg_a.exp_f2 = e2;
        cfg_a.start  = 1'b1;
        tick();
        cfg_a.start  = 1'b0;
    endtask

    // Wait for done on A; optionally scribble on exp inputs at cycle 5 and re-pulse start at cycle 10.
    task automatic wait_done_a(input bit perturb, output int n);
        n = 1;
        while (cfg_a.done !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (perturb && n == 5) begin
                cfg_a.exp_f1 = 16'hFFFF;
                cfg_a.exp_f2 = 16'h0000;
            end
            cfg_a.start = (perturb && n == 10);
        end
        cfg_a.start = 1'b0;
        check("done_a_seen", {31'd0, cfg_a.done}, 32'd1);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_state"}, {30'd0, state_a}, {30'd0, IDLE});
        check({tag, "_busy"},  {31'd0, cfg_a.busy}, 32'd0);
        check({tag, "_done"},  {31'd0, cfg_a.done}, 32'd0);
        check({tag, "_vec"},   {24'd0, vec_abcd_a, vec_wxyz_a}, 32'd0);
        check({tag, "_tt"},    {cfg_a.tt_f1, cfg_a.tt_f2}, 32'd0);
        check({tag, "_mis"},   {26'd0, cfg_a.mismatch_cnt}, 32'd0);
        check({tag, "_pass"},  {31'd0, cfg_a.pass}, 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        cfg_a.start = 1'b0; cfg_a.abort = 1'b0; cfg_a.exp_f1 = 16'd0; cfg_a.exp_f2 = 16'd0;
        cfg_b.start = 1'b0; cfg_b.abort = 1'b0; cfg_b.exp_f1 = 16'd0; cfg_b.exp_f2 = 16'd0;
        tick();
        tick();
        check_reset_a("reset");
        check("reset_b_state", {30'd0, state_b}, {30'd0, IDLE});
        rst = 1'b0;
        tick();

        // Golden sweep
        start_a(F1_GOLDEN, F2_GOLDEN);
        wait_done_a(1'b0, n);
        check("gold_latency", n, 33);
        check("gold_tt_f1", {16'd0, cfg_a.tt_f1}, 32'h35A5);
        check("gold_tt_f2", {16'd0, cfg_a.tt_f2}, 32'hEEE2);
        check("gold_mis", {26'd0, cfg_a.mismatch_cnt}, 32'd0);
        check("gold_busy_in_done", {31'd0, cfg_a.busy}, 32'd0);
        tick();
        check("gold_pass", {31'd0, cfg_a.pass}, 32'd1);
        check("gold_done_pulse", {31'd0, cfg_a.done}, 32'd0);

        // Wrong expectation, exp inputs disturbed mid-sweep and a stray start at cycle 10
        start_a(16'h35A4, 16'hEEE3);
        wait_done_a(1'b1, n);
        check("wrong_latency", n, 33);
        check("wrong_tt_f1", {16'd0, cfg_a.tt_f1}, 32'h35A5);
        check("wrong_tt_f2", {16'd0, cfg_a.tt_f2}, 32'hEEE2);
        check("wrong_mis", {26'd0, cfg_a.mismatch_cnt}, 32'd2);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cfg_a.done === 1'b1) pulses++;
        end
        check("wrong_single_done", pulses, 0);
        check("wrong_pass", {31'd0, cfg_a.pass}, 32'd0);
        check("wrong_idle", {30'd0, state_a}, {30'd0, IDLE});

        // start and abort together in IDLE
        cfg_a.start = 1'b1;
        cfg_a.abort = 1'b1;
        tick();
        cfg_a.start = 1'b0;
        cfg_a.abort = 1'b0;
        check("prio_state", {30'd0, state_a}, {30'd0, IDLE});
        check("prio_busy", {31'd0, cfg_a.busy}, 32'd0);
        tick();
        check("prio_still_idle", {30'd0, state_a}, {30'd0, IDLE});

        // Abort while sampling vector 6
        start_a(F1_GOLDEN, F2_GOLDEN);
        n = 1;
        while (!(vec_abcd_a == 4'd6 && state_a == SAMPLE) && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach_cycle", n, 14);
        cfg_a.abort = 1'b1;
        tick();
        cfg_a.abort = 1'b0;
        check("abort_state", {30'd0, state_a}, {30'd0, IDLE});
        check("abort_busy", {31'd0, cfg_a.busy}, 32'd0);
        check("abort_done", {31'd0, cfg_a.done}, 32'd0);
        check("abort_pass", {31'd0, cfg_a.pass}, 32'd0);
        check("abort_tt_f1", {16'd0, cfg_a.tt_f1}, 32'h0025);
        check("abort_tt_f2", {16'd0, cfg_a.tt_f2}, 32'h0022);
        check("abort_mis", {26'd0, cfg_a.mismatch_cnt}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cfg_a.done === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 0);

        // Reset in the middle of a sweep
        start_a(F1_GOLDEN, F2_GOLDEN);
        for (int i = 1; i < 20; i++) tick();
        check("mid_rst_busy_before", {31'd0, cfg_a.busy}, 32'd1);
        rst = 1'b1;
        tick();
        check_reset_a("mid_rst");
        rst = 1'b0;
        tick();
        start_a(F1_GOLDEN, F2_GOLDEN);
        wait_done_a(1'b0, n);
        check("post_rst_latency", n, 33);
        tick();
        check("post_rst_pass", {31'd0, cfg_a.pass}, 32'd1);

        // Settle of 3 with delayed f1
        cfg_b.exp_f1 = F1_GOLDEN;
        cfg_b.exp_f2 = F2_GOLDEN;
        cfg_b.start  = 1'b1;
        tick();
        cfg_b.start  = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            check($sformatf("slow_vec_c%0d", c),
                  {23'd0, cfg_b.busy, vec_abcd_b, vec_wxyz_b},
                  {23'd0, 1'b1, 4'((c - 1) / 4), 4'((c - 1) / 4)});
            tick();
        end
        check("slow_done_c65", {31'd0, cfg_b.done}, 32'd1);
        check("slow_tt_f1", {16'd0, cfg_b.tt_f1}, 32'h35A5);
        check("slow_tt_f2", {16'd0, cfg_b.tt_f2}, 32'hEEE2);
        tick();
        check("slow_pass", {31'd0, cfg_b.pass}, 32'd1);
        check("slow_mis", {26'd0, cfg_b.mismatch_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
